// File: rtl/b2c1.sv
// b2c1: nibble-to-bit serializer; loads FRAME_NIB nibbles, then streams them out MSB first.
// Optional macro B2C_PINGPONG_EN adds a second buffer so the next frame loads while shifting.
module b2c1 #(
    parameter int FRAME_NIB = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       b2c_en,
    input  logic [3:0] nib_in,
    input  logic       nib_valid,
    output logic       nib_ready,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       bit_sof,
    output logic       bit_eof,
    output logic       busy
);
    localparam int W  = 4 * FRAME_NIB;
    localparam int NW = (FRAME_NIB > 1) ? $clog2(FRAME_NIB) : 1;
    localparam int BW = $clog2(W);
    localparam logic [NW-1:0] LAST_NIB = NW'(FRAME_NIB - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  shift_buf_q, shift_buf_d;
    logic [NW-1:0] nib_cnt_q, nib_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          accept;
    logic          nib_ready_d, bit_out_d, bit_valid_d, bit_sof_d, bit_eof_d, busy_d;
`ifdef B2C_PINGPONG_EN
    logic [W-1:0]  load_buf_q, load_buf_d;
    logic          load_full_q, load_full_d;
`endif

    // Next-state logic; outputs are derived from the next state so they can be registered.
    always_comb begin
        state_d     = state_q;
        shift_buf_d = shift_buf_q;
        nib_cnt_d   = nib_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        accept      = nib_valid && nib_ready;
`ifdef B2C_PINGPONG_EN
        load_buf_d  = load_buf_q;
        load_full_d = load_full_q;
        // The load side runs independently of shifting; a completed frame waits in load_buf.
        if (state_q != IDLE && accept) begin
            load_buf_d = {load_buf_q[W-5:0], nib_in};
            if (nib_cnt_q == LAST_NIB) begin
                nib_cnt_d   = '0;
                load_full_d = 1'b1;
            end else begin
                nib_cnt_d = nib_cnt_q + 1'b1;
            end
        end
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (load_full_d) begin
                    state_d     = SHIFT;
                    shift_buf_d = load_buf_d;
                    load_full_d = 1'b0;
                    bit_cnt_d   = '0;
                end
            end
            SHIFT: begin
                shift_buf_d = {shift_buf_q[W-2:0], 1'b0};
                bit_cnt_d   = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (load_full_d) begin
                        shift_buf_d = load_buf_d;
                        load_full_d = 1'b0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        nib_ready_d = (state_d == LOAD) || (state_d == SHIFT && !load_full_d);
`else
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (accept) begin
                    shift_buf_d = {shift_buf_q[W-5:0], nib_in};
                    if (nib_cnt_q == LAST_NIB) begin
                        state_d   = SHIFT;
                        nib_cnt_d = '0;
                        bit_cnt_d = '0;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 1'b1;
                    end
                end
            end
            SHIFT: begin
                shift_buf_d = {shift_buf_q[W-2:0], 1'b0};
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = LOAD;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        nib_ready_d = (state_d == LOAD);
`endif
        bit_valid_d = (state_d == SHIFT);
        bit_out_d   = (state_d == SHIFT) ? shift_buf_d[W-1] : 1'b0;
        bit_sof_d   = (state_d == SHIFT) && (bit_cnt_d == '0);
        bit_eof_d   = (state_d == SHIFT) && (bit_cnt_d == LAST_BIT);
        busy_d      = (state_d == SHIFT) || (state_d == LOAD && nib_cnt_d != '0);
    end

    // Disable behaves exactly like reset: everything returns to the cleared IDLE state.
    always_ff @(posedge clk) begin
        if (rst || !b2c_en) begin
            state_q     <= IDLE;
            shift_buf_q <= '0;
            nib_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            nib_ready   <= 1'b0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            bit_sof     <= 1'b0;
            bit_eof     <= 1'b0;
            busy        <= 1'b0;
`ifdef B2C_PINGPONG_EN
            load_buf_q  <= '0;
            load_full_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_buf_q <= shift_buf_d;
            nib_cnt_q   <= nib_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            nib_ready   <= nib_ready_d;
            bit_out     <= bit_out_d;
            bit_valid   <= bit_valid_d;
            bit_sof     <= bit_sof_d;
            bit_eof     <= bit_eof_d;
            busy        <= busy_d;
`ifdef B2C_PINGPONG_EN
            load_buf_q  <= load_buf_d;
            load_full_q <= load_full_d;
`endif
        end
    end
endmodule

// File: tb/tb_b2c1.sv
// tb_b2c1: randomized scoreboard bench for b2c1; frames of accepted nibbles are expanded
// into expected bit streams with expected start cycles and compared by a separate monitor.
module tb_b2c1;
    logic       clk = 1'b0;
    logic       rst, b2c_en, nib_valid;
    logic [3:0] nib_in;
    logic       nib_ready, bit_out, bit_valid, bit_sof, bit_eof, busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic exp_bits[$];
    int   exp_sof[$];
    logic [3:0] pend[$];
    int   bitpos = 0;
    int   next_free = 0;
    bit   in_frame = 1'b0;
    bit   prev_eof = 1'b0;

    always #5 clk = ~clk;

    b2c1 dut (
        .clk(clk),
        .rst(rst),
        .b2c_en(b2c_en),
        .nib_in(nib_in),
        .nib_valid(nib_valid),
        .nib_ready(nib_ready),
        .bit_out(bit_out),
        .bit_valid(bit_valid),
        .bit_sof(bit_sof),
        .bit_eof(bit_eof),
        .busy(busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Offer one nibble after an optional random gap and hold it until the DUT accepts it.
    task automatic applyStimulus(input logic [3:0] nib, input int max_gap);
        int  gap;
        bit  got;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
        got = 1'b0;
        if (gap > 0) begin
            nib_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        nib_valid = 1'b1;
        nib_in    = nib;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = (nib_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        if (!got) checkOutput("accept_timeout", {31'b0, got}, 32'd1);
    endtask

    task automatic sendFrame(input logic [63:0] data, input int max_gap);
        for (int i = 15; i >= 0; i--) applyStimulus(data[i*4 +: 4], max_gap);
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 400 && (exp_bits.size() != 0); t++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_remaining", exp_bits.size(), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares outputs first, then records what the coming edge will do.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bit_valid === 1'b1) begin
                if (exp_bits.size() == 0) begin
                    checkOutput("unexpected_bit_valid", {31'b0, bit_valid}, 32'd0);
                end else begin
                    logic b;
                    b = exp_bits.pop_front();
                    if (bitpos == 0) checkOutput("sof_cycle", cyc, exp_sof.pop_front());
                    checkOutput("bit_out", {31'b0, bit_out}, {31'b0, b});
                    checkOutput("bit_sof", {31'b0, bit_sof}, {31'b0, bitpos == 0});
                    checkOutput("bit_eof", {31'b0, bit_eof}, {31'b0, bitpos == 63});
                    in_frame = (bitpos != 63);
                    bitpos   = (bitpos == 63) ? 0 : bitpos + 1;
                end
            end else begin
                if (in_frame) checkOutput("bit_valid_in_frame", {31'b0, bit_valid}, 32'd1);
                checkOutput("idle_markers", {29'b0, bit_out, bit_sof, bit_eof}, 32'd0);
            end
`ifndef B2C_PINGPONG_EN
            if (bit_valid === 1'b1) checkOutput("ready_in_shift", {31'b0, nib_ready}, 32'd0);
`endif
            if (prev_eof) checkOutput("ready_after_eof", {31'b0, nib_ready}, 32'd1);
            checkOutput("busy", {31'b0, busy}, {31'b0, (bit_valid === 1'b1) || (pend.size() != 0)});
            prev_eof = (bit_eof === 1'b1) && b2c_en && !rst;

            if (rst || !b2c_en) begin
                exp_bits.delete();
                exp_sof.delete();
                pend.delete();
                bitpos    = 0;
                in_frame  = 1'b0;
                next_free = 0;
                prev_eof  = 1'b0;
            end else if (nib_valid === 1'b1 && nib_ready === 1'b1) begin
                pend.push_back(nib_in);
                if (pend.size() == 16) begin
                    int s;
                    s = (cyc + 1 > next_free) ? cyc + 1 : next_free;
                    exp_sof.push_back(s);
                    next_free = s + 64;
                    foreach (pend[i]) for (int k = 3; k >= 0; k--) exp_bits.push_back(pend[i][k]);
                    pend.delete();
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        b2c_en    = 1'b1;
        nib_valid = 1'b0;
        nib_in    = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_outputs", {26'b0, nib_ready, bit_out, bit_valid, bit_sof, bit_eof, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_before_release_edge", {31'b0, nib_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("ready_after_release", {31'b0, nib_ready}, 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] ramp frame 0..F back-to-back");
        sendFrame(64'h0123_4567_89AB_CDEF, 0);
        nib_valid = 1'b0;
        waitDrain();

        $display("[TB] all-A frame with random gaps");
        sendFrame(64'hAAAA_AAAA_AAAA_AAAA, 3);
        nib_valid = 1'b0;
        waitDrain();

        $display("[TB] two random frames with valid held through shifting");
        sendFrame({$urandom, $urandom}, 0);
        sendFrame({$urandom, $urandom}, 0);
        nib_valid = 1'b0;
        waitDrain();

        $display("[TB] reset at bit 20 of an all-F frame");
        sendFrame(64'hFFFF_FFFF_FFFF_FFFF, 0);
        nib_valid = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_outputs", {26'b0, nib_ready, bit_out, bit_valid, bit_sof, bit_eof, busy}, 32'd0);
        @(posedge clk);
        #1;
        sendFrame(64'h5555_5555_5555_5555, 0);
        nib_valid = 1'b0;
        waitDrain();

        $display("[TB] disable after 7 nibbles, then re-enable");
        for (int i = 0; i < 7; i++) applyStimulus(4'($urandom), 0);
        nib_valid = 1'b0;
        b2c_en    = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("busy_disabled", {31'b0, busy}, 32'd0);
        checkOutput("ready_disabled", {31'b0, nib_ready}, 32'd0);
        @(posedge clk);
        #1;
        b2c_en = 1'b1;
        sendFrame({$urandom, $urandom}, 1);
        nib_valid = 1'b0;
        waitDrain();

        $display("[TB] random frames with random gaps");
        for (int f = 0; f < 3; f++) sendFrame({$urandom, $urandom}, 2);
        nib_valid = 1'b0;
        waitDrain();

`ifdef B2C_PINGPONG_EN
        $display("[TB] continuous 3/C frames through both buffers");
        sendFrame(64'h3333_3333_3333_3333, 0);
        sendFrame(64'hCCCC_CCCC_CCCC_CCCC, 0);
        nib_valid = 1'b0;
        waitDrain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/b2c1.md
# b2c1

Nibble-to-bit serializer for the turbo codec datapath, the inverse of the encoder's bit-to-nibble packer. It collects one frame of 4-bit symbols over a valid/ready handshake into a 64-bit buffer. It then emits the frame as a continuous serial bit stream with frame-start and frame-end markers. It sits between the nibble-wide codec core and any downstream block that consumes serial bits.

## Interface
- `FRAME_NIB`, default 16: nibbles per frame. The frame length is 4*FRAME_NIB bits, which is 64 at the default.
- `clk`  input  1  single clock; all logic is sampled on the rising edge.
- `rst`  input  1  reset; synchronous and active-high.
- `b2c_en`  input  1  block enable. When low, the block is held cleared exactly as under `rst`.
- `nib_in`  input  4  input symbol.
- `nib_valid`  input  1  `nib_in` is valid this cycle.
- `nib_ready`  output  1  the block accepts a symbol this cycle.
- `bit_out`  output  1  serial data bit.
- `bit_valid`  output  1  `bit_out` is valid this cycle.
- `bit_sof`  output  1  first bit of a frame; only asserted with `bit_valid`.
- `bit_eof`  output  1  last bit of a frame; only asserted with `bit_valid`.
- `busy`  output  1  a frame is partially loaded or currently being shifted out.

## Operation
- State machine: IDLE → LOAD → SHIFT → LOAD.
  - IDLE is entered only from reset or disable.
  - IDLE moves to LOAD on the first cycle with `b2c_en`=1 and `rst`=0.
- LOAD:
  - `nib_ready`=1.
  - A nibble is accepted when `nib_valid` and `nib_ready` are both high.
  - Accepted nibbles are shifted into the buffer: `buf <= {buf[59:0], nib_in}`.
  - A 4-bit counter `nib_cnt` counts accepted nibbles.
  - When nibble number FRAME_NIB-1 (counting from 0) is accepted, the block enters SHIFT.
  - `nib_valid` gaps are allowed and hold state.
- SHIFT:
  - `bit_out` = `buf[63]`, and the buffer shifts left by 1 each cycle.
  - A 6-bit counter `bit_cnt` runs 0..63.
  - `bit_sof` is asserted when `bit_cnt`=0; `bit_eof` is asserted when `bit_cnt`=63.
  - After bit 63 the block returns to LOAD.
- Bit order: the first nibble accepted is the first one sent, MSB first (bit3, bit2, bit1, bit0). This exactly inverts the encoder packer's ordering.
- Single buffer (macro absent): `nib_ready`=0 throughout SHIFT. `nib_valid` asserted during SHIFT is ignored and does not block the block.
- Counters never wrap mid-frame. `nib_cnt` and `bit_cnt` are cleared on each state transition.
- `busy` = (state==SHIFT) or (state==LOAD and `nib_cnt`≠0).
- If `rst` and `b2c_en`=0 occur together, `rst` dominates; both have the same effect.

## Timing
- Reset or disable clears, on the same edge:
  - state to IDLE;
  - the buffer and all counters to 0;
  - `nib_ready`, `bit_out`, `bit_valid`, `bit_sof`, `bit_eof` and `busy` to 0.
- `nib_ready` first rises one cycle after `rst` falls while `b2c_en`=1.
- All outputs are registered.
- Latency:
  - Let E be the edge that accepts the last nibble.
  - Bit 0, together with `bit_valid` and `bit_sof`, is visible in the cycle following E.
  - `bit_valid` then stays high for exactly 64 consecutive cycles.
- Single-buffer mode:
  - `nib_ready` rises in the cycle after the `bit_eof` cycle.
  - The minimum frame period is FRAME_NIB + 64 cycles.
- Reset mid-SHIFT: the stream aborts immediately and no `bit_eof` is produced for the aborted frame. The partial frame is discarded.

## Configuration
- `B2C_PINGPONG_EN` defined:
  - A second 64-bit buffer is compiled in.
  - `nib_ready` stays high during SHIFT whenever the idle buffer is not full.
  - If the next frame is complete when `bit_eof` is output, its `bit_sof` follows in the very next cycle, so bits are emitted continuously at 1 bit/cycle.
  - If the next frame is not complete at that point, `bit_valid` drops until its last nibble is accepted, with the same latency as LOAD.
  - If both buffers are full, `nib_ready`=0.
  - Reset or disable clears both buffers.
- `B2C_PINGPONG_EN` absent: single-buffer behaviour exactly as described above.

## Test plan
- Reset release, then nibbles 0x0..0xF sent back-to-back → 16 accepts, then 64 `bit_valid` cycles carrying 0000 0001 0010 … 1111. `bit_sof` is on the first bit only and `bit_eof` on the 64th only.
- Frame of all 0xA with random one-to-three-cycle `nib_valid` gaps → output is 1010 repeated 16 times. Bit 0 appears in the cycle after the last accept.
- `nib_valid` held high during SHIFT (macro absent) → `nib_ready`=0 for all 64 cycles and no nibble is lost. The next frame starts loading in the cycle after `bit_eof`.
- `rst` pulsed at bit 20 of a 0xFFFF… frame → `bit_valid` is 0 on the following cycle with all outputs 0, and no `bit_eof`. A subsequent 0x5 frame outputs correct 0101 data.
- `b2c_en` dropped after 7 nibbles, then raised → `busy`=0 while disabled. Loading then restarts at nibble 0, and the first frame output is the 16 nibbles sent after re-enable.
- With `B2C_PINGPONG_EN`, two frames 0x3… and 0xC… sent continuously → 128 contiguous `bit_valid` cycles. `bit_eof` at cycle 63 is immediately followed by `bit_sof` at cycle 64.
